// File: rtl/bp_profiler_pkg.sv
// Shared profiler types: stall-reason codes, read FSM states, address-map offsets.
// Used by bp_stall_counter_bank (BP_STALL_COUNTER_SNAPSHOT_EN selects shadow reads).
package bp_profiler_pkg;

  localparam int num_reasons_gp = 32;

  // Offsets past the last stall counter in the read address map
  localparam int instret_addr_off_gp = 0;
  localparam int cycle_addr_off_gp   = 1;

  typedef enum logic [4:0] {
    e_fe_queue_stall   = 5'd0,
    e_fe_wait_stall    = 5'd1,
    e_itlb_miss        = 5'd2,
    e_icache_miss      = 5'd3,
    e_icache_rollback  = 5'd4,
    e_branch_override  = 5'd5,
    e_ret_override     = 5'd6,
    e_fe_cmd           = 5'd7,
    e_fe_cmd_fence     = 5'd8,
    e_mispredict       = 5'd9,
    e_control_haz      = 5'd10,
    e_long_haz         = 5'd11,
    e_data_haz         = 5'd12,
    e_aux_haz          = 5'd13,
    e_load_dep         = 5'd14,
    e_mul_haz          = 5'd15,
    e_fma_haz          = 5'd16,
    e_sb_haz           = 5'd17,
    e_fence_haz        = 5'd18,
    e_dcache_miss      = 5'd19,
    e_dtlb_miss        = 5'd20,
    e_struct_haz       = 5'd21,
    e_exception        = 5'd22,
    e_interrupt        = 5'd23,
    e_unknown          = 5'd31
  } bp_stall_reason_e;

  typedef enum logic {
    e_idle = 1'b0,
    e_resp = 1'b1
  } bp_stall_rd_state_e;

endpackage

// File: rtl/bp_stall_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear takes priority over a same-cycle increment.
module bp_stall_sat_counter #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_r;

  // Count up, stick at all-ones, clear/reset to zero
  always_ff @(posedge clk_i) begin
    if (reset_i | clear_i)
      count_r <= '0;
    else if (up_i && (count_r != '1))
      count_r <= count_r + 1'b1;
  end

  assign count_o = count_r;

endmodule

// File: rtl/bp_stall_counter_bank.sv
// Bank of per-reason stall counters plus instret/cycle counters with a read port.
// BP_STALL_COUNTER_SNAPSHOT_EN: reads return snapshot shadows instead of live values.
module bp_stall_counter_bank
  import bp_profiler_pkg::*;
#(
  parameter int num_reasons_p = num_reasons_gp,
  parameter int cnt_width_p   = 32,
  parameter int addr_width_p  = $clog2(num_reasons_p+2)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             freeze_i,
  input  logic                             instret_i,
  input  logic                             stall_v_i,
  input  logic [$clog2(num_reasons_p)-1:0] stall_reason_i,
  input  logic                             clear_i,
  input  logic                             snapshot_i,
  input  logic                             req_v_i,
  input  logic [addr_width_p-1:0]          req_addr_i,
  output logic                             req_ready_o,
  output logic                             resp_v_o,
  output logic [cnt_width_p-1:0]           resp_data_o,
  output logic                             resp_err_o,
  input  logic                             resp_yumi_i
);

  localparam int total_lp   = num_reasons_p + 2;
  localparam int instret_lp = num_reasons_p + instret_addr_off_gp;
  localparam int cycle_lp   = num_reasons_p + cycle_addr_off_gp;

  logic                   en;
  logic [total_lp-1:0]    up_li;
  logic [cnt_width_p-1:0] cnt_lo [total_lp];
  logic [cnt_width_p-1:0] src    [total_lp];

  assign en = ~freeze_i;

  // Route this cycle's event to exactly the counters it should bump
  always_comb begin
    up_li = '0;
    for (int i = 0; i < num_reasons_p; i++)
      up_li[i] = en & ~instret_i & stall_v_i
               & (int'(stall_reason_i) == i);
    up_li[instret_lp] = en & instret_i;
    up_li[cycle_lp]   = en;
  end

  for (genvar g = 0; g < total_lp; g++) begin : cnt
    bp_stall_sat_counter #(
      .width_p(cnt_width_p)
    ) ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (clear_i),
      .up_i    (up_li[g]),
      .count_o (cnt_lo[g])
    );
  end

`ifdef BP_STALL_COUNTER_SNAPSHOT_EN
  logic [cnt_width_p-1:0] shadow_r [total_lp];

  // Capture pre-increment values; a same-cycle clear captures zero
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < total_lp; i++)
        shadow_r[i] <= '0;
    end else if (snapshot_i) begin
      for (int i = 0; i < total_lp; i++)
        shadow_r[i] <= clear_i ? '0 : cnt_lo[i];
    end
  end

  // Reads see the frozen shadow copy
  always_comb begin
    for (int i = 0; i < total_lp; i++)
      src[i] = shadow_r[i];
  end
`else
  logic unused_snapshot;
  assign unused_snapshot = snapshot_i;

  // Reads see the live counters
  always_comb begin
    for (int i = 0; i < total_lp; i++)
      src[i] = cnt_lo[i];
  end
`endif

  logic [cnt_width_p-1:0] rd_data;
  logic                   rd_err;

  // Address decode; anything past the cycle counter is an error
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    for (int i = 0; i < total_lp; i++) begin
      if (int'(req_addr_i) == i) begin
        rd_data = src[i];
        rd_err  = 1'b0;
      end
    end
  end

  bp_stall_rd_state_e     state_r, state_n;
  logic [cnt_width_p-1:0] resp_data_r;
  logic                   resp_err_r;
  logic                   accept;

  assign accept = req_v_i & (state_r == e_idle);

  // Read FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i)
      state_r <= e_idle;
    else
      state_r <= state_n;
  end

  // Read FSM next state
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_idle: if (req_v_i)     state_n = e_resp;
      e_resp: if (resp_yumi_i) state_n = e_idle;
      default:                 state_n = e_idle;
    endcase
  end

  // Latch the response at acceptance and hold it until consumed
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
    end else if (accept) begin
      resp_data_r <= rd_data;
      resp_err_r  <= rd_err;
    end
  end

  assign req_ready_o = (state_r == e_idle);
  assign resp_v_o    = (state_r == e_resp);
  assign resp_data_o = resp_data_r;
  assign resp_err_o  = resp_err_r;

endmodule

// File: tb/tb_bp_stall_counter_bank.sv
// Directed bench for bp_stall_counter_bank: a 32-bit bank and a 4-bit bank.
// Honors BP_STALL_COUNTER_SNAPSHOT_EN for snapshot-dependent expectations.
module tb_bp_stall_counter_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       freeze = 1'b0;
  logic       instret = 1'b0;
  logic       stall_v = 1'b0;
  logic [4:0] reason = '0;
  logic       clear = 1'b0;
  logic       snapshot = 1'b0;
  logic       req_v = 1'b0;
  logic       req_v_b = 1'b0;
  logic [5:0] addr = '0;
  logic       yumi = 1'b0;
  logic       yumi_b = 1'b0;

  logic        ready_a, resp_v_a, err_a;
  logic [31:0] data_a;
  logic        ready_b, resp_v_b, err_b;
  logic [3:0]  data_b;

  int checks = 0;
  int errors = 0;
  int en_edges = 0;

  always #5 clk = ~clk;

  bp_stall_counter_bank dut_a (
    .clk_i          (clk),
    .reset_i        (reset),
    .freeze_i       (freeze),
    .instret_i      (instret),
    .stall_v_i      (stall_v),
    .stall_reason_i (reason),
    .clear_i        (clear),
    .snapshot_i     (snapshot),
    .req_v_i        (req_v),
    .req_addr_i     (addr),
    .req_ready_o    (ready_a),
    .resp_v_o       (resp_v_a),
    .resp_data_o    (data_a),
    .resp_err_o     (err_a),
    .resp_yumi_i    (yumi)
  );

  bp_stall_counter_bank #(
    .cnt_width_p(4)
  ) dut_b (
    .clk_i          (clk),
    .reset_i        (reset),
    .freeze_i       (freeze),
    .instret_i      (instret),
    .stall_v_i      (stall_v),
    .stall_reason_i (reason),
    .clear_i        (clear),
    .snapshot_i     (snapshot),
    .req_v_i        (req_v_b),
    .req_addr_i     (addr),
    .req_ready_o    (ready_b),
    .resp_v_o       (resp_v_b),
    .resp_data_o    (data_b),
    .resp_err_o     (err_b),
    .resp_yumi_i    (yumi_b)
  );

  // Reference cycle count: enabled edges since last reset/clear
  always @(posedge clk) begin
    if (reset || clear)
      en_edges = 0;
    else if (!freeze)
      en_edges = en_edges + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full read; cycle reads take their expectation from the model
  task automatic rd(input bit inst_b, input int a,
                    input logic [31:0] exp_in,
                    input bit is_cycle, input bit do_snap,
                    input string tag);
    logic [31:0] sv, exp;
    logic        eerr;
    sv = en_edges;
    if (do_snap) begin
      snapshot = 1'b1;
      step(1);
      snapshot = 1'b0;
    end
`ifdef BP_STALL_COUNTER_SNAPSHOT_EN
    exp = is_cycle ? sv : exp_in;
`else
    exp = is_cycle ? en_edges : exp_in;
`endif
    eerr = (a >= 34);
    if (eerr) exp = '0;
    addr = a[5:0];
    if (inst_b) req_v_b = 1'b1;
    else        req_v = 1'b1;
    step(1);
    req_v = 1'b0;
    req_v_b = 1'b0;
    if (inst_b) begin
      chk({tag, "_v"}, {31'b0, resp_v_b}, 32'd1);
      chk({tag, "_data"}, {28'b0, data_b}, exp);
      chk({tag, "_err"}, {31'b0, err_b}, {31'b0, eerr});
      yumi_b = 1'b1;
    end else begin
      chk({tag, "_v"}, {31'b0, resp_v_a}, 32'd1);
      chk({tag, "_data"}, data_a, exp);
      chk({tag, "_err"}, {31'b0, err_a}, {31'b0, eerr});
      yumi = 1'b1;
    end
    step(1);
    yumi = 1'b0;
    yumi_b = 1'b0;
    if (inst_b) chk({tag, "_rdy"}, {31'b0, ready_b}, 32'd1);
    else        chk({tag, "_rdy"}, {31'b0, ready_a}, 32'd1);
  endtask

  initial begin
    step(3);
    chk("rst_ready", {31'b0, ready_a}, 32'd1);
    chk("rst_resp_v", {31'b0, resp_v_a}, 32'd0);
    chk("rst_data", data_a, 32'd0);
    chk("rst_err", {31'b0, err_a}, 32'd0);
    chk("rst_ready_b", {31'b0, ready_b}, 32'd1);
    reset = 1'b0;

    // Five stalls on reason 3
    stall_v = 1'b1;
    reason = 5'd3;
    step(5);
    stall_v = 1'b0;
    rd(0, 3, 32'd5, 0, 1, "r3_five");
    rd(0, 33, 32'd0, 1, 1, "cycle_a");

    // Retire wins over stall
    instret = 1'b1;
    stall_v = 1'b1;
    reason = 5'd2;
    step(4);
    instret = 1'b0;
    stall_v = 1'b0;
    rd(0, 32, 32'd4, 0, 1, "instret4");
    rd(0, 2, 32'd0, 0, 1, "r2_zero");

    // Saturation on the 4-bit bank
    stall_v = 1'b1;
    reason = 5'd0;
    step(20);
    stall_v = 1'b0;
    rd(1, 0, 32'd15, 0, 1, "sat_b");
    rd(0, 0, 32'd20, 0, 1, "r0_twenty");

    // Frozen: neither cycle nor stall counters move
    freeze = 1'b1;
    stall_v = 1'b1;
    rd(0, 33, 32'd0, 1, 1, "frz_cyc1");
    step(3);
    rd(0, 33, 32'd0, 1, 1, "frz_cyc2");
    rd(0, 0, 32'd20, 0, 1, "frz_r0");
    stall_v = 1'b0;
    freeze = 1'b0;

    // Clear beats a same-cycle stall
    stall_v = 1'b1;
    reason = 5'd3;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    stall_v = 1'b0;
    rd(0, 3, 32'd0, 0, 1, "clr_r3");
    rd(0, 0, 32'd0, 0, 1, "clr_r0");
    rd(0, 32, 32'd0, 0, 1, "clr_inst");
    rd(0, 33, 32'd0, 1, 1, "clr_cyc");
    rd(1, 0, 32'd0, 0, 1, "clr_b");

    // Held response ignores later clear/counting
    stall_v = 1'b1;
    reason = 5'd3;
    step(2);
    stall_v = 1'b0;
    snapshot = 1'b1;
    step(1);
    snapshot = 1'b0;
    addr = 6'd3;
    req_v = 1'b1;
    step(1);
    req_v = 1'b0;
    clear = 1'b1;
    stall_v = 1'b1;
    chk("hold_d0", data_a, 32'd2);
    step(1);
    clear = 1'b0;
    chk("hold_d1", data_a, 32'd2);
    chk("hold_v1", {31'b0, resp_v_a}, 32'd1);
    step(1);
    chk("hold_d2", data_a, 32'd2);
    stall_v = 1'b0;
    yumi = 1'b1;
    step(1);
    yumi = 1'b0;
    chk("hold_rdy", {31'b0, ready_a}, 32'd1);

    // Out-of-range address with a slow consumer
    addr = 6'd37;
    req_v = 1'b1;
    step(1);
    req_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("oor_v", {31'b0, resp_v_a}, 32'd1);
      chk("oor_err", {31'b0, err_a}, 32'd1);
      chk("oor_data", data_a, 32'd0);
      chk("oor_rdy", {31'b0, ready_a}, 32'd0);
      step(1);
    end
    yumi = 1'b1;
    chk("oor_rdy_yumi", {31'b0, ready_a}, 32'd0);
    step(1);
    yumi = 1'b0;
    chk("oor_rdy_after", {31'b0, ready_a}, 32'd1);
    chk("oor_v_after", {31'b0, resp_v_a}, 32'd0);

    // Snapshot freezes the read view
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    stall_v = 1'b1;
    reason = 5'd1;
    step(3);
    stall_v = 1'b0;
    snapshot = 1'b1;
    step(1);
    snapshot = 1'b0;
    stall_v = 1'b1;
    step(2);
    stall_v = 1'b0;
`ifdef BP_STALL_COUNTER_SNAPSHOT_EN
    rd(0, 1, 32'd3, 0, 0, "snap_r1");
`else
    rd(0, 1, 32'd5, 0, 0, "snap_r1");
`endif

    // Snapshot with clear captures zero
    stall_v = 1'b1;
    reason = 5'd4;
    step(2);
    stall_v = 1'b0;
    clear = 1'b1;
    snapshot = 1'b1;
    step(1);
    clear = 1'b0;
    snapshot = 1'b0;
    rd(0, 4, 32'd0, 0, 0, "snapclr_r4");

    // Reset drops a pending response
    addr = 6'd1;
    req_v = 1'b1;
    step(1);
    req_v = 1'b0;
    chk("rstp_v", {31'b0, resp_v_a}, 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rstp_v0", {31'b0, resp_v_a}, 32'd0);
    chk("rstp_rdy", {31'b0, ready_a}, 32'd1);
    chk("rstp_data", data_a, 32'd0);
    chk("rstp_err", {31'b0, err_a}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
